// File: rtl/run_length_detector_pkg.sv
// rtl/run_length_detector_pkg.sv - shared state encoding and mode constants for run-length detectors
package run_length_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HIT  = 2'b10
    } state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/run_length_detector_hit_sat_counter.sv
// rtl/run_length_detector_hit_sat_counter.sv - saturating up-counter with synchronous clear
module hit_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - Moore detector for RUN_LEN consecutive samples at a chosen polarity
module run_length_detector
    import run_length_detector_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8,
    localparam int RW     = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             en,
    input  logic             w,
    input  logic             pol,
    input  logic             mode,
    input  logic             clr,
    output logic             z,
    output logic [RW-1:0]    run_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [RW-1:0] RUN_LEN_V = RW'(RUN_LEN);

    state_t        r_state;
    logic [RW-1:0] r_run_cnt;
    logic          r_z;

    logic          w_match;
    logic [RW-1:0] w_run_nxt;
    state_t        w_state_nxt;
    logic          w_state_legal;
    logic          w_hit_inc;

    always_comb begin
        w_match   = (w == pol);
        w_run_nxt = '0;
        if (w_match) begin
            // At a full run: level mode saturates, pulse mode restarts at 1.
            if (r_run_cnt >= RUN_LEN_V) begin
                w_run_nxt = (mode == MODE_PULSE) ? RW'(1) : RUN_LEN_V;
            end else begin
                w_run_nxt = r_run_cnt + RW'(1);
            end
        end

        if (w_run_nxt == '0) begin
            w_state_nxt = IDLE;
        end else if (w_run_nxt == RUN_LEN_V) begin
            w_state_nxt = HIT;
        end else begin
            w_state_nxt = RUN;
        end

        case (r_state)
            IDLE, RUN, HIT: w_state_legal = 1'b1;
            default:        w_state_legal = 1'b0;
        endcase

        w_hit_inc = en && w_state_legal && (w_state_nxt == HIT) &&
                    ((mode == MODE_PULSE) || (r_state != HIT));
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_z       <= 1'b0;
        end else if (!w_state_legal) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_z       <= 1'b0;
        end else if (en) begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_z       <= (w_state_nxt == HIT);
        end
    end

    hit_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk    (clk),
        .Resetn (Resetn),
        .i_inc  (w_hit_inc),
        .i_clr  (clr),
        .o_cnt  (hit_cnt)
    );

    assign z       = r_z;
    assign run_cnt = r_run_cnt;

endmodule

// File: tb/tb_run_length_detector.sv
// tb/tb_run_length_detector.sv - directed self-checking bench for run_length_detector
module tb_run_length_detector;

    logic clk = 1'b0;
    logic Resetn = 1'b0;
    logic en = 1'b0;
    logic w = 1'b0;
    logic pol = 1'b1;
    logic mode = 1'b0;
    logic clr = 1'b0;

    logic       z2, z3, z1, z1n;
    logic [1:0] run2, run3;
    logic [0:0] run1, run1n;
    logic [7:0] hit2, hit3, hit1;
    logic [1:0] hit1n;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    run_length_detector #(.RUN_LEN(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .Resetn(Resetn), .en(en), .w(w), .pol(pol), .mode(mode), .clr(clr),
        .z(z2), .run_cnt(run2), .hit_cnt(hit2));
    run_length_detector #(.RUN_LEN(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .Resetn(Resetn), .en(en), .w(w), .pol(pol), .mode(mode), .clr(clr),
        .z(z3), .run_cnt(run3), .hit_cnt(hit3));
    run_length_detector #(.RUN_LEN(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .Resetn(Resetn), .en(en), .w(w), .pol(pol), .mode(mode), .clr(clr),
        .z(z1), .run_cnt(run1), .hit_cnt(hit1));
    run_length_detector #(.RUN_LEN(1), .CNT_W(2)) u_dut1n (
        .clk(clk), .Resetn(Resetn), .en(en), .w(w), .pol(pol), .mode(mode), .clr(clr),
        .z(z1n), .run_cnt(run1n), .hit_cnt(hit1n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        #2;
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({z2, run2, hit2} !== 11'd0) $display("FAIL reset_dut2 got %0d/%0d/%0d exp 0/0/0", z2, run2, hit2);
        else n_pass++;
        n_total++;
        if ({z3, run3, hit3, z1n, hit1n} !== 14'd0) $display("FAIL reset_others got %0d/%0d/%0d exp 0/0/0", z3, run3, hit1n);
        else n_pass++;
        Resetn = 1'b1;
    endtask

    task automatic test_level_rl2();
        logic [4:0] wv = 5'b01110;
        int ez[5] = '{0, 0, 1, 1, 0};
        int er[5] = '{0, 1, 2, 2, 0};
        en = 1'b1; pol = 1'b1; mode = 1'b0; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w = wv[4-i];
            tick();
            n_total++;
            if (z2 !== ez[i][0] || run2 !== er[i][1:0])
                $display("FAIL level_rl2[%0d] got z=%0d run=%0d exp z=%0d run=%0d", i, z2, run2, ez[i], er[i]);
            else n_pass++;
        end
        n_total++;
        if (hit2 !== 8'd1) $display("FAIL level_rl2_hit got %0d exp 1", hit2);
        else n_pass++;
    endtask

    task automatic test_pulse_rl3();
        int er[7] = '{1, 2, 3, 1, 2, 3, 1};
        int ez[7] = '{0, 0, 1, 0, 0, 1, 0};
        do_reset();
        en = 1'b1; pol = 1'b1; mode = 1'b1; w = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_total++;
            if (z3 !== ez[i][0] || run3 !== er[i][1:0])
                $display("FAIL pulse_rl3[%0d] got z=%0d run=%0d exp z=%0d run=%0d", i, z3, run3, ez[i], er[i]);
            else n_pass++;
        end
        n_total++;
        if (hit3 !== 8'd2) $display("FAIL pulse_rl3_hit got %0d exp 2", hit3);
        else n_pass++;
    endtask

    task automatic test_pol0_and_rl1();
        logic [3:0] wv = 4'b0001;
        int ez[4] = '{0, 0, 1, 0};
        do_reset();
        en = 1'b1; pol = 1'b0; mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = wv[3-i];
            tick();
            n_total++;
            if (z3 !== ez[i][0]) $display("FAIL pol0_rl3[%0d] got z=%0d exp %0d", i, z3, ez[i]);
            else n_pass++;
        end
        n_total++;
        if (hit1 !== 8'd1) $display("FAIL rl1_level_hit got %0d exp 1", hit1);
        else n_pass++;
        pol = 1'b1; mode = 1'b1; w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (z1 !== 1'b1 || hit1 !== 8'(i + 2))
                $display("FAIL rl1_pulse[%0d] got z=%0d hit=%0d exp z=1 hit=%0d", i, z1, hit1, i + 2);
            else n_pass++;
        end
    endtask

    task automatic test_enable_and_clr();
        logic [3:0] ev = 4'b1001;
        int er[4] = '{1, 1, 1, 2};
        int ez[4] = '{0, 0, 0, 1};
        do_reset();
        pol = 1'b1; mode = 1'b0; w = 1'b1; clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = ev[3-i];
            tick();
            n_total++;
            if (z2 !== ez[i][0] || run2 !== er[i][1:0])
                $display("FAIL enable[%0d] got z=%0d run=%0d exp z=%0d run=%0d", i, z2, run2, ez[i], er[i]);
            else n_pass++;
        end
        n_total++;
        if (hit2 !== 8'd1) $display("FAIL enable_hit got %0d exp 1", hit2);
        else n_pass++;
        w = 1'b0; tick();
        w = 1'b1; tick();
        clr = 1'b1; tick();
        clr = 1'b0;
        n_total++;
        if (z2 !== 1'b1 || hit2 !== 8'd0) $display("FAIL clr_priority got z=%0d hit=%0d exp z=1 hit=0", z2, hit2);
        else n_pass++;
        w = 1'b0; tick();
        w = 1'b1; tick();
        tick();
        n_total++;
        if (hit2 !== 8'd1) $display("FAIL rehit got %0d exp 1", hit2);
        else n_pass++;
        en = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;
        n_total++;
        if (hit2 !== 8'd0 || z2 !== 1'b1 || run2 !== 2'd2)
            $display("FAIL clr_no_en got hit=%0d z=%0d run=%0d exp hit=0 z=1 run=2", hit2, z2, run2);
        else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1; pol = 1'b1; mode = 1'b1; w = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (hit1n !== 2'((i < 3) ? i + 1 : 3))
                $display("FAIL saturate[%0d] got %0d exp %0d", i, hit1n, (i < 3) ? i + 1 : 3);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; pol = 1'b1; mode = 1'b0; w = 1'b1;
        tick();
        tick();
        n_total++;
        if (z2 !== 1'b1) $display("FAIL pre_async_z got %0d exp 1", z2);
        else n_pass++;
        #1;
        Resetn = 1'b0;
        #1;
        n_total++;
        if (z2 !== 1'b0 || run2 !== 2'd0 || hit2 !== 8'd0)
            $display("FAIL async_reset got z=%0d run=%0d hit=%0d exp 0/0/0", z2, run2, hit2);
        else n_pass++;
        #1;
        Resetn = 1'b1;
        tick();
        n_total++;
        if (run2 !== 2'd1 || z2 !== 1'b0) $display("FAIL post_reset got run=%0d z=%0d exp run=1 z=0", run2, z2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_level_rl2();
        test_pulse_rl3();
        test_pol0_and_rl1();
        test_enable_and_clr();
        test_saturate();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
